// File: rtl/fifo_buffer_pkg.sv
// rtl/fifo_buffer_pkg.sv - shared word format and FIFO default constants
// Shared by the FIFO and the downstream destination arbiter.
package fifo_buffer_pkg;

    localparam int FB_DATA_WIDTH = 10;
    localparam int FB_DEST_MSB   = 9;
    localparam int FB_DEST_LSB   = 8;
    localparam int FB_DEST_W     = FB_DEST_MSB - FB_DEST_LSB + 1;

    localparam int FB_DEPTH      = 8;
    localparam int FB_AF_TH      = 6;
    localparam int FB_AE_TH      = 2;

    typedef logic [FB_DATA_WIDTH-1:0] fb_word_t;
    typedef logic [FB_DEST_W-1:0]     fb_dest_t;

    typedef struct packed {
        logic empty;
        logic almost_empty;
        logic almost_full;
        logic full;
    } fb_flags_t;

endpackage

// File: rtl/fifo_buffer_if.sv
// rtl/fifo_buffer_if.sv - push/pop handshake and status bundle for fifo_buffer
// level exposes the registered occupancy for monitoring.
interface fifo_buffer_if #(
    parameter int DATA_WIDTH = 10,
    parameter int DEPTH      = 8
);
    logic                     push;
    logic                     pop;
    logic [DATA_WIDTH-1:0]    data_in;
    logic [DATA_WIDTH-1:0]    data_out;
    logic                     valid_out;
    logic                     empty;
    logic                     full;
    logic                     almost_empty;
    logic                     almost_full;
    logic                     fifo_error;
    logic [$clog2(DEPTH):0]   level;

    modport master (
        output push, pop, data_in,
        input  data_out, valid_out, empty, full, almost_empty, almost_full,
               fifo_error, level
    );

    modport slave (
        input  push, pop, data_in,
        output data_out, valid_out, empty, full, almost_empty, almost_full,
               fifo_error, level
    );

endinterface

// File: rtl/fifo_buffer_mem.sv
// rtl/fifo_buffer_mem.sv - DEPTH x DATA_WIDTH register array storage
// Synchronous write, combinational read; contents are deliberately not reset.
module fifo_mem
    import fifo_buffer_pkg::*;
#(
    parameter int DATA_WIDTH = FB_DATA_WIDTH,
    parameter int DEPTH      = FB_DEPTH,
    parameter int ADDR_W     = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_W-1:0]     raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_buffer.sv
// rtl/fifo_buffer.sv - circular-buffer FIFO with registered read and sticky error
// Pointers, occupancy, flag decode and error tracking; storage lives in fifo_mem.
module fifo_buffer
    import fifo_buffer_pkg::*;
#(
    parameter int DATA_WIDTH = FB_DATA_WIDTH,
    parameter int DEPTH      = FB_DEPTH,
    parameter int AF_TH      = FB_AF_TH,
    parameter int AE_TH      = FB_AE_TH
) (
    input  logic          clk,
    input  logic          reset,
    fifo_buffer_if.slave  bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_AF   = CNT_W'(AF_TH);
    localparam logic [CNT_W-1:0] CNT_AE   = CNT_W'(AE_TH);

    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count;
    logic [DATA_WIDTH-1:0] rd_word;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  valid_q;
    logic                  error_q;
    fb_flags_t             flags;

    logic push_ok;
    logic pop_ok;
    logic overflow;
    logic underflow;

    // Flags come from the registered count only, never from push/pop.
    always_comb begin
        flags              = '0;
        flags.empty        = (count == '0);
        flags.full         = (count == CNT_FULL);
        flags.almost_empty = (count <= CNT_AE);
        flags.almost_full  = (count >= CNT_AF);
    end

    // A push into a full FIFO is still taken when a pop frees the slot on the same edge.
    always_comb begin
        pop_ok    = bus.pop && !flags.empty;
        push_ok   = bus.push && (!flags.full || pop_ok);
        overflow  = bus.push && flags.full && !pop_ok;
        underflow = bus.pop && flags.empty;
    end

    fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_W     (PTR_W)
    ) u_mem (
        .clk   (clk),
        .we    (push_ok),
        .waddr (wr_ptr),
        .wdata (bus.data_in),
        .raddr (rd_ptr),
        .rdata (rd_word)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            error_q <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
                data_q <= rd_word;
            end
            valid_q <= pop_ok;

            case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase

            if (overflow || underflow) begin
                error_q <= 1'b1;
            end
        end
    end

    assign bus.data_out     = data_q;
    assign bus.valid_out    = valid_q;
    assign bus.empty        = flags.empty;
    assign bus.full         = flags.full;
    assign bus.almost_empty = flags.almost_empty;
    assign bus.almost_full  = flags.almost_full;
    assign bus.fifo_error   = error_q;
    assign bus.level        = count;

endmodule

// File: tb/tb_fifo_buffer.sv
// tb/tb_fifo_buffer.sv - directed self-checking bench for fifo_buffer
// Linear directed steps; expected values are hand-computed constants.
module tb_fifo_buffer;

    logic clk;
    logic reset;
    int   total;
    int   passed;

    fifo_buffer_if #(.DATA_WIDTH(10), .DEPTH(8)) bus ();

    fifo_buffer #(
        .DATA_WIDTH (10),
        .DEPTH      (8),
        .AF_TH      (6),
        .AE_TH      (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Drive one cycle of inputs, then sample 1 time unit after the edge.
    task automatic cycle(input logic p, input logic q, input logic [9:0] d);
        bus.push    = p;
        bus.pop     = q;
        bus.data_in = d;
        @(posedge clk);
        #1;
        bus.push    = 1'b0;
        bus.pop     = 1'b0;
        bus.data_in = '0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        total       = 0;
        passed      = 0;
        reset       = 1'b0;
        bus.push    = 1'b0;
        bus.pop     = 1'b0;
        bus.data_in = '0;
        #2;
        do_reset();

        // Reset then idle
        cycle(1'b0, 1'b0, 10'h000);
        chk("rst_empty",    32'(bus.empty),        32'd1);
        chk("rst_aempty",   32'(bus.almost_empty), 32'd1);
        chk("rst_full",     32'(bus.full),         32'd0);
        chk("rst_afull",    32'(bus.almost_full),  32'd0);
        chk("rst_data",     32'(bus.data_out),     32'h000);
        chk("rst_valid",    32'(bus.valid_out),    32'd0);
        chk("rst_error",    32'(bus.fifo_error),   32'd0);
        chk("rst_level",    32'(bus.level),        32'd0);

        // Three words with distinct destinations, read back in order
        cycle(1'b1, 1'b0, 10'h100);
        cycle(1'b1, 1'b0, 10'h201);
        cycle(1'b1, 1'b0, 10'h302);
        chk("p3_level",     32'(bus.level),        32'd3);
        chk("p3_aempty",    32'(bus.almost_empty), 32'd0);
        cycle(1'b0, 1'b1, 10'h000);
        chk("pop1_data",    32'(bus.data_out),     32'h100);
        chk("pop1_valid",   32'(bus.valid_out),    32'd1);
        cycle(1'b0, 1'b1, 10'h000);
        chk("pop2_data",    32'(bus.data_out),     32'h201);
        chk("pop2_valid",   32'(bus.valid_out),    32'd1);
        cycle(1'b0, 1'b1, 10'h000);
        chk("pop3_data",    32'(bus.data_out),     32'h302);
        chk("pop3_valid",   32'(bus.valid_out),    32'd1);
        chk("pop3_empty",   32'(bus.empty),        32'd1);
        cycle(1'b0, 1'b0, 10'h000);
        chk("idle_valid",   32'(bus.valid_out),    32'd0);
        chk("idle_hold",    32'(bus.data_out),     32'h302);

        // Fill to full, watch threshold flags, then overflow
        for (int i = 1; i <= 8; i++) begin
            cycle(1'b1, 1'b0, 10'(i - 1));
            chk($sformatf("fill%0d_afull", i),  32'(bus.almost_full),  (i >= 6) ? 32'd1 : 32'd0);
            chk($sformatf("fill%0d_full", i),   32'(bus.full),         (i == 8) ? 32'd1 : 32'd0);
            chk($sformatf("fill%0d_aempty", i), 32'(bus.almost_empty), (i <= 2) ? 32'd1 : 32'd0);
        end
        chk("fill_error",   32'(bus.fifo_error),   32'd0);
        cycle(1'b1, 1'b0, 10'h3FF);
        chk("ovf_level",    32'(bus.level),        32'd8);
        chk("ovf_full",     32'(bus.full),         32'd1);
        chk("ovf_error",    32'(bus.fifo_error),   32'd1);
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, 1'b1, 10'h000);
            chk($sformatf("drain%0d_data", i), 32'(bus.data_out), 32'(i));
        end
        chk("drain_empty",  32'(bus.empty),        32'd1);
        chk("drain_error",  32'(bus.fifo_error),   32'd1);

        // Full FIFO with simultaneous push and pop
        do_reset();
        chk("rst2_error",   32'(bus.fifo_error),   32'd0);
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 1'b0, 10'(10'h010 + i));
        end
        cycle(1'b1, 1'b1, 10'h2AA);
        chk("fpp_data",     32'(bus.data_out),     32'h010);
        chk("fpp_level",    32'(bus.level),        32'd8);
        chk("fpp_full",     32'(bus.full),         32'd1);
        chk("fpp_error",    32'(bus.fifo_error),   32'd0);
        for (int i = 1; i < 8; i++) begin
            cycle(1'b0, 1'b1, 10'h000);
            chk($sformatf("fpp_drain%0d", i), 32'(bus.data_out), 32'(10'h010 + i));
        end
        cycle(1'b0, 1'b1, 10'h000);
        chk("fpp_last",     32'(bus.data_out),     32'h2AA);
        chk("fpp_empty",    32'(bus.empty),        32'd1);

        // Underflow on empty, then push+pop on empty
        cycle(1'b0, 1'b1, 10'h000);
        chk("unf_valid",    32'(bus.valid_out),    32'd0);
        chk("unf_hold",     32'(bus.data_out),     32'h2AA);
        chk("unf_error",    32'(bus.fifo_error),   32'd1);
        cycle(1'b1, 1'b1, 10'h155);
        chk("epp_level",    32'(bus.level),        32'd1);
        chk("epp_valid",    32'(bus.valid_out),    32'd0);
        chk("epp_hold",     32'(bus.data_out),     32'h2AA);
        cycle(1'b0, 1'b1, 10'h000);
        chk("epp_pop",      32'(bus.data_out),     32'h155);

        // Reset asserted mid-cycle with 5 words stored
        do_reset();
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 1'b0, 10'(10'h0C0 + i));
        end
        chk("mid_level",    32'(bus.level),        32'd5);
        chk("mid_empty",    32'(bus.empty),        32'd0);
        #2;
        reset = 1'b0;
        #1;
        chk("async_empty",  32'(bus.empty),        32'd1);
        chk("async_aempty", 32'(bus.almost_empty), 32'd1);
        chk("async_level",  32'(bus.level),        32'd0);
        chk("async_full",   32'(bus.full),         32'd0);
        bus.push    = 1'b1;
        bus.pop     = 1'b1;
        bus.data_in = 10'h111;
        @(posedge clk);
        #1;
        bus.push    = 1'b0;
        bus.pop     = 1'b0;
        chk("inrst_level",  32'(bus.level),        32'd0);
        chk("inrst_valid",  32'(bus.valid_out),    32'd0);
        reset = 1'b1;
        cycle(1'b0, 1'b1, 10'h000);
        chk("post_valid",   32'(bus.valid_out),    32'd0);
        chk("post_data",    32'(bus.data_out),     32'h000);
        chk("post_error",   32'(bus.fifo_error),   32'd1);
        chk("post_empty",   32'(bus.empty),        32'd1);
        cycle(1'b1, 1'b0, 10'h0AB);
        chk("post_level",   32'(bus.level),        32'd1);
        cycle(1'b0, 1'b1, 10'h000);
        chk("post_pop",     32'(bus.data_out),     32'h0AB);
        chk("post_pvalid",  32'(bus.valid_out),    32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/fifo_buffer.md
FIFO_BUFFER -- requirements
Module: fifo_buffer

Interface
REQ-001 Parameter DATA_WIDTH, default 10, word width; bits [9:8] carry the destination and pass through untouched.
REQ-002 Parameter DEPTH, default 8, number of entries; power of two, 4 or greater.
REQ-003 Parameter AF_TH, default 6, almost-full threshold (occupancy).
REQ-004 Parameter AE_TH, default 2, almost-empty threshold (occupancy).
REQ-005 clk  input  1  single clock, rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 push  input  1  write request, data_in sampled same edge.
REQ-008 pop  input  1  read request.
REQ-009 data_in  input  DATA_WIDTH  write word.
REQ-010 data_out  output  DATA_WIDTH  registered read word.
REQ-011 valid_out  output  1  data_out holds a word popped on the previous edge.
REQ-012 empty  output  1  occupancy == 0.
REQ-013 full  output  1  occupancy == DEPTH.
REQ-014 almost_empty  output  1  occupancy <= AE_TH.
REQ-015 almost_full  output  1  occupancy >= AF_TH.
REQ-016 fifo_error  output  1  sticky overflow/underflow indicator.

Function
REQ-017 Storage SHALL be a circular buffer with write pointer, read pointer and occupancy counter.
- Pointers: log2(DEPTH) bits, wrap from DEPTH-1 to 0.
- Counter: log2(DEPTH)+1 bits.
REQ-018 An accepted push SHALL write data_in at the write pointer and advance it by one on the same edge.
REQ-019 An accepted pop SHALL load data_out from the read pointer, advance the read pointer, and set valid_out high for exactly the next cycle.
- Read latency: 1 cycle.
REQ-020 When no pop is accepted, data_out SHALL hold its last value and valid_out SHALL be 0.
REQ-021 Occupancy SHALL change per edge as follows:
- push only: +1
- pop only: -1
- both accepted: unchanged
- neither: unchanged
REQ-022 Push while full:
- with an accepted pop: both SHALL be accepted.
- without a pop: the push SHALL be dropped, with no pointer or count change, and fifo_error set.
REQ-023 Pop while empty SHALL be ignored (data_out held, valid_out 0) and SHALL set fifo_error.
- A simultaneous push is still accepted; write-through to data_out is not provided.
REQ-024 fifo_error SHALL remain 1 until reset.
REQ-025 empty, full, almost_empty and almost_full SHALL be combinational decodes of the registered occupancy only, with no path from push or pop.
REQ-026 Pop accepted at edge N SHALL present data_out valid during cycle N+1, so that a downstream arbiter's destination decode two cycles after pop reads a stable word.

Reset
REQ-027 reset low SHALL asynchronously force the following:
- pointers = 0, occupancy = 0
- data_out = 0, valid_out = 0, fifo_error = 0
- resulting flags: empty = 1, full = 0, almost_empty = 1, almost_full = 0
REQ-028 Storage array contents SHALL NOT be reset.
REQ-029 Reset asserted mid-operation SHALL discard all stored words; push and pop SHALL be ignored while reset is low.
REQ-030 The first accepted operation after reset SHALL be on the first rising edge with reset high.

Structure
REQ-031 The shared package SHALL hold DATA_WIDTH, the destination field position [9:8], and the default DEPTH/AF_TH/AE_TH constants, for use by this block and the arbiter.
REQ-032 Storage SHALL be one sub-module, fifo_mem: a DEPTH x DATA_WIDTH register array with synchronous write port and combinational read port.
- Pointer, counter, flag and error logic SHALL live in fifo_buffer.

Verification
REQ-033 Reset then idle -> empty = 1, almost_empty = 1, full = 0, almost_full = 0, data_out = 0x000, valid_out = 0, fifo_error = 0.
REQ-034 Push 0x100, 0x201, 0x302, then pop 3 times -> data_out 0x100, 0x201, 0x302 each one cycle after its pop with valid_out = 1; empty = 1 after the third pop.
REQ-035 Push 8 words 0x000..0x007 -> almost_full rises after the 6th push and full after the 8th; a 9th push (0x3FF) is dropped with fifo_error = 1; popping 8 returns 0x000..0x007.
REQ-036 Full FIFO, push 0x2AA with simultaneous pop -> occupancy stays 8, full stays 1, fifo_error stays 0, and 0x2AA is the last word read out.
REQ-037 Empty FIFO, pop alone -> valid_out = 0, data_out unchanged, fifo_error = 1; push+pop on empty -> occupancy becomes 1.
REQ-038 Push 5 words, assert reset low mid-cycle -> flags return to reset values immediately (asynchronously); after release, pop on empty sets fifo_error and returns no stale data.
